// File: rtl/serial_bus_arbiter_2m.sv
// Two-master round-robin arbiter and router for the 1-bit serial bus.
// Captures the granted master's address, selects a slave from its top two bits, replays the address and streams data.
module serial_bus_arbiter_2m #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int SLAVE_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic m1_request,
  input  logic m2_request,
  input  logic m1_address,
  input  logic m2_address,
  input  logic m1_data,
  input  logic m2_data,
  input  logic m1_valid,
  input  logic m2_valid,
  input  logic m1_address_valid,
  input  logic m2_address_valid,
  output logic m1_grant,
  output logic m2_grant,
  output logic m1_ready,
  output logic m2_ready,
  input  logic s1_ready,
  input  logic s2_ready,
  input  logic s3_ready,
  output logic s1_address,
  output logic s2_address,
  output logic s3_address,
  output logic s1_data,
  output logic s2_data,
  output logic s3_data,
  output logic s1_valid,
  output logic s2_valid,
  output logic s3_valid,
  output logic bus_error
);

  localparam int BIT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(BIT_MAX + 1);
  localparam int TO_W    = $clog2(SLAVE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(SLAVE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ADDR_CAPTURE = 3'd1,
    WAIT_SLAVE   = 3'd2,
    ADDR_FWD     = 3'd3,
    DATA         = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic                  m1_grant_r, m1_grant_s, m2_grant_r, m2_grant_s;
  logic                  m1_ready_r, m1_ready_s, m2_ready_r, m2_ready_s;
  logic                  last_served_r, last_served_s;   // 1: m2 was served last
  logic [1:0]            sel_r, sel_s;
  logic [ADDR_WIDTH-1:0] addr_sr_r, addr_sr_s, addr_shift_s;
  logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_s;
  logic [TO_W-1:0]       to_cnt_r, to_cnt_s;
  logic                  marker_seen_r, marker_seen_s;
  logic [2:0]            slv_addr_r, slv_addr_s, slv_data_r, slv_data_s, slv_valid_r, slv_valid_s;
  logic                  bus_error_r, bus_error_s;
  logic                  mx_valid_s, mx_av_s, mx_addr_s, mx_data_s, sel_ready_s;
  logic [2:0]            sel_onehot_s;
  logic                  fail_s, release_s;

  function automatic logic [2:0] slave_onehot(input logic [1:0] sel);
    case (sel)
      2'b00:   slave_onehot = 3'b001;
      2'b01:   slave_onehot = 3'b010;
      2'b10:   slave_onehot = 3'b100;
      default: slave_onehot = 3'b000;
    endcase
  endfunction

  // Route only the granted master's inputs; the other master is invisible.
  always_comb begin
    if (m2_grant_r) begin
      mx_valid_s = m2_valid;
      mx_av_s    = m2_address_valid;
      mx_addr_s  = m2_address;
      mx_data_s  = m2_data;
    end else begin
      mx_valid_s = m1_valid & m1_grant_r;
      mx_av_s    = m1_address_valid & m1_grant_r;
      mx_addr_s  = m1_address;
      mx_data_s  = m1_data;
    end
    case (sel_r)
      2'b00:   sel_ready_s = s1_ready;
      2'b01:   sel_ready_s = s2_ready;
      2'b10:   sel_ready_s = s3_ready;
      default: sel_ready_s = 1'b0;
    endcase
    sel_onehot_s = slave_onehot(sel_r);
    addr_shift_s = {addr_sr_r[ADDR_WIDTH-2:0], mx_addr_s};
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_s       = state_r;
    m1_grant_s    = m1_grant_r;
    m2_grant_s    = m2_grant_r;
    m1_ready_s    = m1_ready_r;
    m2_ready_s    = m2_ready_r;
    last_served_s = last_served_r;
    sel_s         = sel_r;
    addr_sr_s     = addr_sr_r;
    bit_cnt_s     = bit_cnt_r;
    to_cnt_s      = to_cnt_r;
    marker_seen_s = marker_seen_r;
    slv_addr_s    = 3'b000;
    slv_data_s    = 3'b000;
    slv_valid_s   = 3'b000;
    bus_error_s   = 1'b0;
    fail_s        = 1'b0;
    release_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (m1_request || m2_request) begin
          if (m1_request && (!m2_request || last_served_r)) begin
            m1_grant_s = 1'b1;
          end else begin
            m2_grant_s = 1'b1;
          end
          state_s       = ADDR_CAPTURE;
          marker_seen_s = 1'b0;
          bit_cnt_s     = '0;
          to_cnt_s      = '0;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR_CAPTURE: begin
        if (!marker_seen_r) begin
          if (mx_valid_s && mx_av_s) begin
            marker_seen_s = 1'b1;
            bit_cnt_s     = '0;
          end else if (to_cnt_r == TO_LAST) begin
            fail_s = 1'b1;
          end else begin
            to_cnt_s = to_cnt_r + TO_W'(1);
          end
        end else if (!mx_valid_s) begin
          fail_s = 1'b1;
        end else begin
          addr_sr_s = addr_shift_s;
          if (bit_cnt_r == ADDR_LAST) begin
            bit_cnt_s = '0;
            if (addr_shift_s[ADDR_WIDTH-1 -: 2] == 2'b11) begin
              fail_s = 1'b1;
            end else begin
              sel_s    = addr_shift_s[ADDR_WIDTH-1 -: 2];
              state_s  = WAIT_SLAVE;
              to_cnt_s = '0;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + CNT_W'(1);
          end
        end
      end
      WAIT_SLAVE: begin
        if (sel_ready_s) begin
          state_s     = ADDR_FWD;
          slv_valid_s = sel_onehot_s;
          slv_addr_s  = addr_sr_r[ADDR_WIDTH-1] ? sel_onehot_s : 3'b000;
          addr_sr_s   = {addr_sr_r[ADDR_WIDTH-2:0], 1'b0};
          bit_cnt_s   = CNT_W'(1);
        end else if (to_cnt_r == TO_LAST) begin
          fail_s = 1'b1;
        end else begin
          to_cnt_s = to_cnt_r + TO_W'(1);
        end
      end
      ADDR_FWD: begin
        if (!mx_valid_s) begin
          fail_s = 1'b1;
        end else begin
          slv_valid_s = sel_onehot_s;
          slv_addr_s  = addr_sr_r[ADDR_WIDTH-1] ? sel_onehot_s : 3'b000;
          addr_sr_s   = {addr_sr_r[ADDR_WIDTH-2:0], 1'b0};
          // Raise ready alongside the last address bit so data follows without a gap.
          if (bit_cnt_r == ADDR_LAST) begin
            state_s    = DATA;
            bit_cnt_s  = '0;
            m1_ready_s = m1_grant_r;
            m2_ready_s = m2_grant_r;
          end else begin
            bit_cnt_s = bit_cnt_r + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (mx_valid_s) begin
          slv_valid_s = sel_onehot_s;
          slv_data_s  = mx_data_s ? sel_onehot_s : 3'b000;
          if (bit_cnt_r == DATA_LAST) begin
            release_s = 1'b1;
          end else begin
            bit_cnt_s = bit_cnt_r + CNT_W'(1);
          end
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (fail_s) begin
      bus_error_s = 1'b1;
      slv_addr_s  = 3'b000;
      slv_data_s  = 3'b000;
      slv_valid_s = 3'b000;
    end else begin
      bus_error_s = 1'b0;
    end
    if (fail_s || release_s) begin
      state_s       = IDLE;
      m1_grant_s    = 1'b0;
      m2_grant_s    = 1'b0;
      m1_ready_s    = 1'b0;
      m2_ready_s    = 1'b0;
      last_served_s = m2_grant_r;
      bit_cnt_s     = '0;
      to_cnt_s      = '0;
      marker_seen_s = 1'b0;
    end else begin
      last_served_s = last_served_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      m1_grant_r    <= 1'b0;
      m2_grant_r    <= 1'b0;
      m1_ready_r    <= 1'b0;
      m2_ready_r    <= 1'b0;
      last_served_r <= 1'b1;
      sel_r         <= 2'b00;
      addr_sr_r     <= '0;
      bit_cnt_r     <= '0;
      to_cnt_r      <= '0;
      marker_seen_r <= 1'b0;
      slv_addr_r    <= 3'b000;
      slv_data_r    <= 3'b000;
      slv_valid_r   <= 3'b000;
      bus_error_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      m1_grant_r    <= m1_grant_s;
      m2_grant_r    <= m2_grant_s;
      m1_ready_r    <= m1_ready_s;
      m2_ready_r    <= m2_ready_s;
      last_served_r <= last_served_s;
      sel_r         <= sel_s;
      addr_sr_r     <= addr_sr_s;
      bit_cnt_r     <= bit_cnt_s;
      to_cnt_r      <= to_cnt_s;
      marker_seen_r <= marker_seen_s;
      slv_addr_r    <= slv_addr_s;
      slv_data_r    <= slv_data_s;
      slv_valid_r   <= slv_valid_s;
      bus_error_r   <= bus_error_s;
    end
  end

  assign m1_grant   = m1_grant_r;
  assign m2_grant   = m2_grant_r;
  assign m1_ready   = m1_ready_r;
  assign m2_ready   = m2_ready_r;
  assign s1_address = slv_addr_r[0];
  assign s2_address = slv_addr_r[1];
  assign s3_address = slv_addr_r[2];
  assign s1_data    = slv_data_r[0];
  assign s2_data    = slv_data_r[1];
  assign s3_data    = slv_data_r[2];
  assign s1_valid   = slv_valid_r[0];
  assign s2_valid   = slv_valid_r[1];
  assign s3_valid   = slv_valid_r[2];
  assign bus_error  = bus_error_r;

endmodule

// File: tb/tb_serial_bus_arbiter_2m.sv
// Directed bench for serial_bus_arbiter_2m: transfers, contention, errors, stall, abort and async reset.
module tb_serial_bus_arbiter_2m;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] m_req = 2'b00, m_addr = 2'b00, m_data = 2'b00, m_valid = 2'b00, m_av = 2'b00;
  logic [2:0] s_rdy = 3'b000;
  wire  [1:0] grant, m_rdy;
  wire  [2:0] s_addr, s_data, s_valid;
  wire        bus_err;

  int checks = 0;
  int errors = 0;
  logic mon_clr = 1'b0;
  int scnt [3];
  int dgap [3];
  int stray [3];
  logic [63:0] sstream [3];
  int err_pulses, err_wide, overlap, gap_bad;
  logic err_prev;
  logic [1:0] prev_grant;
  int who, who2, who3, c;

  serial_bus_arbiter_2m dut (
    .clk(clk), .reset(reset),
    .m1_request(m_req[0]), .m2_request(m_req[1]),
    .m1_address(m_addr[0]), .m2_address(m_addr[1]),
    .m1_data(m_data[0]), .m2_data(m_data[1]),
    .m1_valid(m_valid[0]), .m2_valid(m_valid[1]),
    .m1_address_valid(m_av[0]), .m2_address_valid(m_av[1]),
    .m1_grant(grant[0]), .m2_grant(grant[1]),
    .m1_ready(m_rdy[0]), .m2_ready(m_rdy[1]),
    .s1_ready(s_rdy[0]), .s2_ready(s_rdy[1]), .s3_ready(s_rdy[2]),
    .s1_address(s_addr[0]), .s2_address(s_addr[1]), .s3_address(s_addr[2]),
    .s1_data(s_data[0]), .s2_data(s_data[1]), .s3_data(s_data[2]),
    .s1_valid(s_valid[0]), .s2_valid(s_valid[1]), .s3_valid(s_valid[2]),
    .bus_error(bus_err)
  );

  always #5 clk = ~clk;

  // Slave-side stream recorder and bus-property counters.
  always @(negedge clk) begin
    if (mon_clr) begin
      for (int k = 0; k < 3; k++) begin
        scnt[k] <= 0; dgap[k] <= 0; stray[k] <= 0; sstream[k] <= 64'd0;
      end
      err_pulses <= 0; err_wide <= 0; overlap <= 0; gap_bad <= 0;
      err_prev <= 1'b0; prev_grant <= 2'b00;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (s_valid[k]) begin
          sstream[k] <= {sstream[k][62:0], s_addr[k] | s_data[k]};
          scnt[k]    <= scnt[k] + 1;
        end else begin
          if (s_addr[k] | s_data[k]) stray[k] <= stray[k] + 1;
          if (scnt[k] >= 16 && scnt[k] < 24) dgap[k] <= dgap[k] + 1;
        end
      end
      if (bus_err) err_pulses <= err_pulses + 1;
      if (bus_err && err_prev) err_wide <= err_wide + 1;
      if (grant == 2'b11) overlap <= overlap + 1;
      if (prev_grant != 2'b00 && grant != 2'b00 && prev_grant != grant) gap_bad <= gap_bad + 1;
      err_prev   <= bus_err;
      prev_grant <= grant;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] all_outs();
    all_outs = {grant, m_rdy, s_valid, s_addr, s_data, bus_err};
  endfunction

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  // Acts as whichever master is granted: marker, address, then nbits data bits.
  task automatic serve(input logic [15:0] a, input logic [7:0] d, input bit keep_req,
                       input int nbits, input int stall_at, input int stall_len,
                       input int abort_at, output int w);
    int t, idx, j, st;
    bit aborted;
    t = 0;
    while (grant == 2'b00 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("grant_wait", (t < 100), 1);
    w   = grant[1] ? 2 : 1;
    idx = w - 1;
    if (!keep_req) m_req[idx] = 1'b0;
    m_valid[idx] = 1'b1;
    m_av[idx]    = 1'b1;
    m_addr[idx]  = 1'b1;
    aborted = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      m_av[idx] = 1'b0;
      if (i == abort_at) begin
        m_valid[idx] = 1'b0;
        m_addr[idx]  = 1'b0;
        aborted      = 1'b1;
        break;
      end
      m_addr[idx] = a[15-i];
    end
    if (!aborted && nbits > 0) begin
      j = 0; st = 0; t = 0;
      while (j < nbits && t < 300) begin
        @(negedge clk);
        t++;
        m_addr[idx] = 1'b0;
        if (m_rdy[idx]) begin
          if (j == stall_at && st < stall_len) begin
            m_valid[idx] = 1'b0;
            m_data[idx]  = 1'b0;
            st++;
          end else begin
            m_valid[idx] = 1'b1;
            m_data[idx]  = d[7-j];
            j++;
          end
        end
      end
      chk("data_wait", (t < 300), 1);
      if (nbits == 8) begin
        @(negedge clk);
        chk("ready_drop", m_rdy[idx], 0);
        chk("grant_drop", grant[idx], 0);
        m_valid[idx] = 1'b0;
        m_data[idx]  = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    reset = 1'b0;
    clr_mon();

    // Single transfer m1 -> s2
    s_rdy = 3'b010;
    m_req = 2'b01;
    @(negedge clk);
    chk("t1_grant_lat", grant, 2'b01);
    serve(16'h5A3C, 8'hB5, 1'b0, 8, -1, 0, -1, who);
    settle();
    chk("t1_who", who, 1);
    chk("t1_s2_bits", scnt[1], 24);
    chk("t1_s2_stream", sstream[1][23:0], {16'h5A3C, 8'hB5});
    chk("t1_other_slaves", scnt[0] + scnt[2], 0);
    chk("t1_stray", stray[0] + stray[1] + stray[2], 0);
    chk("t1_dgap", dgap[1], 0);
    chk("t1_err", err_pulses, 0);

    // Contention from reset: m1, m2, m1
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clr_mon();
    s_rdy = 3'b111;
    m_req = 2'b11;
    serve(16'h1234, 8'hA5, 1'b1, 8, -1, 0, -1, who);
    serve(16'h1234, 8'hA5, 1'b1, 8, -1, 0, -1, who2);
    serve(16'h1234, 8'hA5, 1'b1, 8, -1, 0, -1, who3);
    m_req = 2'b00;
    settle();
    chk("t2_first", who, 1);
    chk("t2_second", who2, 2);
    chk("t2_third", who3, 1);
    chk("t2_overlap", overlap, 0);
    chk("t2_idle_gap", gap_bad, 0);
    chk("t2_s1_bits", scnt[0], 72);
    chk("t2_s1_stream", sstream[0][23:0], {16'h1234, 8'hA5});
    chk("t2_err", err_pulses, 0);

    // Request drops after grant, no marker: timeout from grant
    clr_mon();
    m_req = 2'b10;
    @(negedge clk);
    chk("t3_grant", grant, 2'b10);
    m_req = 2'b00;
    c = 0;
    while (!bus_err && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t3_marker_timeout", c, 64);
    chk("t3_grant_rel", grant, 2'b00);
    settle();
    chk("t3_err_pulses", err_pulses, 1);

    // Bad select 0xC000
    clr_mon();
    s_rdy = 3'b111;
    m_req = 2'b01;
    serve(16'hC000, 8'h00, 1'b0, 0, -1, 0, -1, who);
    @(negedge clk);
    chk("t4_err", bus_err, 1);
    chk("t4_grant_rel", grant, 2'b00);
    m_valid = 2'b00;
    m_addr  = 2'b00;
    @(negedge clk);
    chk("t4_err_width", bus_err, 0);
    settle();
    chk("t4_no_valid", scnt[0] + scnt[1] + scnt[2], 0);

    // Slave timeout on s3 (m2); error 64 cycles after WAIT_SLAVE entry,
    // which is the edge after the last address bit, hence 65 negedges from here
    clr_mon();
    s_rdy = 3'b000;
    m_req = 2'b10;
    serve(16'h8001, 8'h00, 1'b0, 0, -1, 0, -1, who);
    chk("t5_who", who, 2);
    c = 0;
    while (!bus_err && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("t5_timeout_cycles", c, 65);
    chk("t5_grant_rel", grant, 2'b00);
    m_valid = 2'b00;
    m_addr  = 2'b00;
    settle();
    chk("t5_s3_none", scnt[2], 0);
    chk("t5_err_wide", err_wide, 0);

    // s3 ready late: forward begins the next cycle; then abort during forward
    clr_mon();
    m_req = 2'b01;
    serve(16'h8001, 8'h00, 1'b0, 0, -1, 0, -1, who);
    repeat (10) @(negedge clk);
    chk("t6_pre_fwd", s_valid, 3'b000);
    s_rdy[2] = 1'b1;
    @(negedge clk);
    chk("t6_fwd_valid", s_valid, 3'b100);
    chk("t6_fwd_msb", s_addr, 3'b100);
    m_valid = 2'b00;
    @(negedge clk);
    chk("t6_abort_err", bus_err, 1);
    chk("t6_abort_outs", all_outs() >> 1, 0);
    s_rdy  = 3'b000;
    m_addr = 2'b00;
    settle();

    // Stall three cycles mid-data
    clr_mon();
    s_rdy = 3'b001;
    m_req = 2'b01;
    serve(16'h0F0F, 8'h6C, 1'b0, 8, 3, 3, -1, who);
    settle();
    chk("t7_bits", scnt[0], 24);
    chk("t7_stream", sstream[0][23:0], {16'h0F0F, 8'h6C});
    chk("t7_stall_gap", dgap[0], 3);
    chk("t7_err", err_pulses, 0);

    // Valid dropped mid-address
    clr_mon();
    m_req = 2'b01;
    serve(16'h1234, 8'h00, 1'b0, 8, -1, 0, 5, who);
    @(negedge clk);
    chk("t8_abort_err", bus_err, 1);
    chk("t8_abort_outs", all_outs() >> 1, 0);
    @(negedge clk);
    chk("t8_err_width", bus_err, 0);

    // Async reset mid-DATA, then m1 wins the tie
    clr_mon();
    s_rdy = 3'b100;
    m_req = 2'b01;
    serve(16'h8888, 8'hFF, 1'b0, 3, -1, 0, -1, who);
    chk("t9_in_data", m_rdy[0], 1);
    chk("t9_streaming", s_valid, 3'b100);
    #2 reset = 1'b1;
    #1 chk("t9_reset_outs", all_outs(), 0);
    @(negedge clk);
    reset   = 1'b0;
    m_valid = 2'b00;
    m_data  = 2'b00;
    m_req   = 2'b11;
    @(negedge clk);
    chk("t9_tie_after_reset", grant, 2'b01);
    m_req = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
